// File: rtl/ascon_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ascon_pkg
//  Description : Shared types and constants for the Ascon permutation
//                datapath. Holds the 5x64 state type and the enum for
//                the folded substitution layer's control FSM.
//  Revision    : 1.0 - initial release
// ============================================================================
package ascon_pkg;

  localparam int ASCON_NUM_LANES  = 5;
  localparam int ASCON_LANE_WIDTH = 64;

  // Index 0 is lane s0, which is the MSB of every S-box column.
  typedef logic [ASCON_NUM_LANES-1:0][ASCON_LANE_WIDTH-1:0] t_state_array;

  // Control states of the folded substitution layer.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } t_subst_state;

endpackage : ascon_pkg
`default_nettype wire

// File: rtl/substitution_layer_folded_sbox.sv
`default_nettype none
// ============================================================================
//  Module      : sbox
//  Description : Ascon 5-bit S-box (chi-like core with affine pre/post
//                layers). Input and output are packed {x0,x1,x2,x3,x4},
//                x0 being the MSB. Purely combinational.
//  Revision    : 1.0 - initial release
// ============================================================================
module sbox (
  input  logic [4:0] i_x,
  output logic [4:0] o_y
);

  // Unpacked view of the column, x0 = MSB.
  logic w_x0, w_x1, w_x2, w_x3, w_x4;
  // After the input affine layer.
  logic w_a0, w_a2, w_a4;
  // Nonlinear terms ~x[i] & x[i+1].
  logic w_t0, w_t1, w_t2, w_t3, w_t4;
  // After the nonlinear layer.
  logic w_b0, w_b1, w_b2, w_b3, w_b4;

  assign w_x0 = i_x[4];
  assign w_x1 = i_x[3];
  assign w_x2 = i_x[2];
  assign w_x3 = i_x[1];
  assign w_x4 = i_x[0];

  // Input affine layer: x0^=x4, x4^=x3, x2^=x1.
  assign w_a0 = w_x0 ^ w_x4;
  assign w_a4 = w_x4 ^ w_x3;
  assign w_a2 = w_x2 ^ w_x1;

  // Nonlinear layer on (a0, x1, a2, x3, a4).
  assign w_t0 = ~w_a0 & w_x1;
  assign w_t1 = ~w_x1 & w_a2;
  assign w_t2 = ~w_a2 & w_x3;
  assign w_t3 = ~w_x3 & w_a4;
  assign w_t4 = ~w_a4 & w_a0;

  assign w_b0 = w_a0 ^ w_t1;
  assign w_b1 = w_x1 ^ w_t2;
  assign w_b2 = w_a2 ^ w_t3;
  assign w_b3 = w_x3 ^ w_t4;
  assign w_b4 = w_a4 ^ w_t0;

  // Output affine layer: x1^=x0, x0^=x4, x3^=x2, x2=~x2.
  assign o_y[4] = w_b0 ^ w_b4;
  assign o_y[3] = w_b1 ^ w_b0;
  assign o_y[2] = ~w_b2;
  assign o_y[1] = w_b3 ^ w_b2;
  assign o_y[0] = w_b4;

endmodule : sbox
`default_nettype wire

// File: rtl/substitution_layer_folded.sv
`default_nettype none
// ============================================================================
//  Module      : substitution_layer_folded
//  Description : Time-multiplexed Ascon substitution layer. A bank of
//                G_SBOXES_PER_CYCLE S-boxes walks the 64 state columns
//                over 64/G_SBOXES_PER_CYCLE cycles, rewriting the working
//                register in place. Valid/ready on both sides.
//  Options     : ASCON_SUBST_CLEAR_EN - adds i_clear, a synchronous
//                highest-priority wipe of FSM, counter and working state.
//  Revision    : 1.0 - initial release
// ============================================================================
module substitution_layer_folded
  import ascon_pkg::*;
#(
  parameter int G_SBOXES_PER_CYCLE = 16,
  parameter int G_NUM_COLUMNS      = 64
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
`ifdef ASCON_SUBST_CLEAR_EN
  input  logic         i_clear,
`endif
  input  logic         i_valid,
  output logic         o_ready,
  input  t_state_array i_state,
  output logic         o_valid,
  input  logic         i_ready,
  output t_state_array o_state
);

  localparam int C_P          = G_SBOXES_PER_CYCLE;
  localparam int C_NUM_SLICES = G_NUM_COLUMNS / G_SBOXES_PER_CYCLE;
  localparam int C_CNT_W      = (C_NUM_SLICES > 1) ? $clog2(C_NUM_SLICES) : 1;
  localparam int C_COL_W      = (G_NUM_COLUMNS > 1) ? $clog2(G_NUM_COLUMNS) : 1;
  localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(C_NUM_SLICES - 1);

  // Reject configurations where the S-box bank does not tile the lane
  // exactly, or where the column count disagrees with the state type.
  if ((G_SBOXES_PER_CYCLE < 1) || ((G_NUM_COLUMNS % G_SBOXES_PER_CYCLE) != 0)) begin : g_bad_sbox_count
    $error("G_NUM_COLUMNS must be a multiple of G_SBOXES_PER_CYCLE");
  end
  if (G_NUM_COLUMNS != ASCON_LANE_WIDTH) begin : g_bad_num_columns
    $error("G_NUM_COLUMNS must equal ASCON_LANE_WIDTH");
  end

  t_subst_state r_fsm;
  logic [C_CNT_W-1:0] r_cnt;
  t_state_array r_state;
  logic r_valid;

  // First column of the slice handled this cycle.
  logic [C_COL_W-1:0] w_base;
  // Current slice of each lane, and the substituted replacement.
  logic [ASCON_NUM_LANES-1:0][C_P-1:0] w_slice;
  logic [ASCON_NUM_LANES-1:0][C_P-1:0] w_sub;

  // With a single slice the base is always column 0; keeping this out of the
  // multiply avoids a constant that does not fit the column-index width.
  if (C_NUM_SLICES == 1) begin : g_base_single
    assign w_base = '0;
  end else begin : g_base_multi
    localparam logic [C_COL_W-1:0] C_COL_P = C_COL_W'(C_P);
    assign w_base = C_COL_W'(r_cnt) * C_COL_P;
  end

  // Column mux: pull the active slice of every lane out of the working register.
  always_comb begin
    w_slice = '0;
    for (int l = 0; l < ASCON_NUM_LANES; l++) begin
      w_slice[l] = r_state[l][w_base +: C_P];
    end
  end

  // S-box bank; column j of the slice is {s0,s1,s2,s3,s4} with s0 as MSB.
  for (genvar j = 0; j < C_P; j++) begin : g_sbox
    logic [4:0] w_col_in;
    logic [4:0] w_col_out;

    assign w_col_in = {w_slice[0][j], w_slice[1][j], w_slice[2][j],
                       w_slice[3][j], w_slice[4][j]};

    sbox u_sbox (
      .i_x (w_col_in),
      .o_y (w_col_out)
    );

    assign w_sub[0][j] = w_col_out[4];
    assign w_sub[1][j] = w_col_out[3];
    assign w_sub[2][j] = w_col_out[2];
    assign w_sub[3][j] = w_col_out[1];
    assign w_sub[4][j] = w_col_out[0];
  end

  // Control FSM, slice counter, output-valid flag and in-place working register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fsm   <= IDLE;
      r_cnt   <= '0;
      r_state <= '0;
      r_valid <= 1'b0;
    end
`ifdef ASCON_SUBST_CLEAR_EN
    else if (i_clear) begin
      // Abort path: scrub intermediate secret state, ignore any offered input.
      r_fsm   <= IDLE;
      r_cnt   <= '0;
      r_state <= '0;
      r_valid <= 1'b0;
    end
`endif
    else begin
      case (r_fsm)
        IDLE: begin
          if (i_valid) begin
            r_state <= i_state;
            r_cnt   <= '0;
            r_fsm   <= BUSY;
          end
        end

        BUSY: begin
          for (int l = 0; l < ASCON_NUM_LANES; l++) begin
            r_state[l][w_base +: C_P] <= w_sub[l];
          end
          if (r_cnt == C_CNT_LAST) begin
            r_cnt   <= '0;
            r_fsm   <= DONE;
            r_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt + C_CNT_W'(1);
          end
        end

        DONE: begin
          // Result is held untouched until the consumer takes it.
          if (i_ready) begin
            r_valid <= 1'b0;
            if (i_valid) begin
              r_state <= i_state;
              r_cnt   <= '0;
              r_fsm   <= BUSY;
            end else begin
              r_fsm <= IDLE;
            end
          end
        end

        default: begin
          r_fsm   <= IDLE;
          r_cnt   <= '0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  // Ready: always in IDLE; in DONE only when the result is drained this cycle.
  always_comb begin
    o_ready = (r_fsm == IDLE) || ((r_fsm == DONE) && i_ready);
`ifdef ASCON_SUBST_CLEAR_EN
    if (i_clear) begin
      o_ready = 1'b0;
    end
`endif
  end

  assign o_valid = r_valid;
  assign o_state = r_state;

endmodule : substitution_layer_folded
`default_nettype wire

// File: tb/tb_substitution_layer_folded.sv
`default_nettype none
// ============================================================================
//  Module      : tb_substitution_layer_folded
//  Description : Self-checking bench for the folded Ascon substitution layer.
//                Three instances (16, 1 and 64 S-boxes per cycle) are driven
//                with directed and random states; expected results come from
//                a table-driven p_S model and are matched by per-instance
//                monitors. Define ASCON_SUBST_CLEAR_EN to cover i_clear.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_substitution_layer_folded;
  import ascon_pkg::*;

  localparam int NDUT = 3;

  function automatic int p_of(int k);
    return (k == 0) ? 16 : ((k == 1) ? 1 : 64);
  endfunction

  function automatic int n_of(int k);
    return 64 / p_of(k);
  endfunction

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic         valid_i [NDUT];
  logic         ready_i [NDUT];
  logic         ready_o [NDUT];
  logic         valid_o [NDUT];
  t_state_array state_i [NDUT];
  t_state_array state_o [NDUT];
`ifdef ASCON_SUBST_CLEAR_EN
  logic         clear_i [NDUT];
`endif

  // Scoreboard: expected result and the cycle number of the accepting edge.
  t_state_array exp_q [NDUT][$];
  int           acc_q [NDUT][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  function automatic logic [4:0] sbox_ref(logic [4:0] v);
    case (v)
      5'h00: return 5'h04; 5'h01: return 5'h0b; 5'h02: return 5'h1f; 5'h03: return 5'h14;
      5'h04: return 5'h1a; 5'h05: return 5'h15; 5'h06: return 5'h09; 5'h07: return 5'h02;
      5'h08: return 5'h1b; 5'h09: return 5'h05; 5'h0a: return 5'h08; 5'h0b: return 5'h12;
      5'h0c: return 5'h1d; 5'h0d: return 5'h03; 5'h0e: return 5'h06; 5'h0f: return 5'h1c;
      5'h10: return 5'h1e; 5'h11: return 5'h13; 5'h12: return 5'h07; 5'h13: return 5'h0e;
      5'h14: return 5'h00; 5'h15: return 5'h0d; 5'h16: return 5'h11; 5'h17: return 5'h18;
      5'h18: return 5'h10; 5'h19: return 5'h0c; 5'h1a: return 5'h01; 5'h1b: return 5'h19;
      5'h1c: return 5'h16; 5'h1d: return 5'h0a; 5'h1e: return 5'h0f; default: return 5'h17;
    endcase
  endfunction

  function automatic t_state_array ref_ps(t_state_array s);
    t_state_array r;
    logic [4:0]   v;
    logic [4:0]   o;
    r = '0;
    for (int c = 0; c < 64; c++) begin
      for (int l = 0; l < 5; l++) v[4-l] = s[l][c];
      o = sbox_ref(v);
      for (int l = 0; l < 5; l++) r[l][c] = o[4-l];
    end
    return r;
  endfunction

  function automatic t_state_array rand_state();
    t_state_array s;
    for (int l = 0; l < 5; l++) s[l] = {$urandom(), $urandom()};
    return s;
  endfunction

  // ---------------- comparison helpers ----------------
  task automatic check_state(string name, t_state_array act, t_state_array exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_bit(string name, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_int(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- DUTs and monitors ----------------
  for (genvar k = 0; k < NDUT; k++) begin : g_dut
    substitution_layer_folded #(
      .G_SBOXES_PER_CYCLE (p_of(k)),
      .G_NUM_COLUMNS      (64)
    ) u_dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
`ifdef ASCON_SUBST_CLEAR_EN
      .i_clear (clear_i[k]),
`endif
      .i_valid (valid_i[k]),
      .o_ready (ready_o[k]),
      .i_state (state_i[k]),
      .o_valid (valid_o[k]),
      .i_ready (ready_i[k]),
      .o_state (state_o[k])
    );

    logic prev_v = 1'b0;

    // Each new result (rising o_valid) is matched against the scoreboard.
    always @(negedge clk) begin
      t_state_array e;
      int           a;
      if (valid_o[k] && !prev_v) begin
        if (exp_q[k].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output dut%0d: got %h expected no output", k, state_o[k]);
        end else begin
          e = exp_q[k].pop_front();
          a = acc_q[k].pop_front();
          check_state($sformatf("result_dut%0d", k), state_o[k], e);
          check_int($sformatf("latency_dut%0d", k), cyc - a, n_of(k));
        end
      end
      prev_v = valid_o[k];
    end
  end

  // ---------------- stimulus helpers (called just after a negedge) ----------------
  task automatic send(int k, t_state_array s);
    bit done;
    done = 1'b0;
    valid_i[k] = 1'b1;
    state_i[k] = s;
    for (int n = 0; n < 300 && !done; n++) begin
      #1;
      if (ready_o[k]) begin
        exp_q[k].push_back(ref_ps(s));
        acc_q[k].push_back(cyc + 1);
        done = 1'b1;
      end
      @(negedge clk);
    end
    valid_i[k] = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout dut%0d: got ready=0 expected ready=1 within 300 cycles", k);
    end
  endtask

  task automatic wait_valid(int k);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 300 && !seen; n++) begin
      #1;
      if (valid_o[k]) seen = 1'b1;
      else @(negedge clk);
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL valid_timeout dut%0d: got o_valid=0 expected 1 within 300 cycles", k);
    end
  endtask

  task automatic drop_pending(int k);
    exp_q[k].delete();
    acc_q[k].delete();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    t_state_array a_st;
    t_state_array b_st;
    t_state_array exp_c;

    for (int k = 0; k < NDUT; k++) begin
      valid_i[k] = 1'b0;
      ready_i[k] = 1'b1;
      state_i[k] = '0;
`ifdef ASCON_SUBST_CLEAR_EN
      clear_i[k] = 1'b0;
`endif
    end

    // Reset values
    repeat (3) @(negedge clk);
    for (int k = 0; k < NDUT; k++) begin
      check_bit($sformatf("rst_valid_dut%0d", k), valid_o[k], 1'b0);
      check_bit($sformatf("rst_ready_dut%0d", k), ready_o[k], 1'b1);
      check_state($sformatf("rst_state_dut%0d", k), state_o[k], '0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // All-zero state: lane 2 becomes all ones
    send(0, '0);
    wait_valid(0);
    exp_c = '0;
    exp_c[2] = '1;
    check_state("zero_state", state_o[0], exp_c);
    @(negedge clk);

    // All-ones state: column 0x1F -> 0x17
    send(0, '1);
    wait_valid(0);
    exp_c = '1;
    exp_c[1] = '0;
    check_state("ones_state", state_o[0], exp_c);
    @(negedge clk);

    // Random states on every folding factor, single-shot then back-to-back
    for (int k = 0; k < NDUT; k++) begin
      for (int t = 0; t < 3; t++) begin
        send(k, rand_state());
        wait_valid(k);
        @(negedge clk);
      end
      for (int t = 0; t < 4; t++) send(k, rand_state());
      wait_valid(k);
      repeat (3) @(negedge clk);
    end

    // Back-pressure: result held while a new state waits at the input
    ready_i[0] = 1'b0;
    a_st = rand_state();
    send(0, a_st);
    wait_valid(0);
    b_st = rand_state();
    valid_i[0] = 1'b1;
    state_i[0] = b_st;
    for (int n = 0; n < 10; n++) begin
      #1;
      check_state("hold_state", state_o[0], ref_ps(a_st));
      check_bit("hold_ready", ready_o[0], 1'b0);
      check_bit("hold_valid", valid_o[0], 1'b1);
      @(negedge clk);
    end
    ready_i[0] = 1'b1;
    #1;
    check_bit("release_ready", ready_o[0], 1'b1);
    exp_q[0].push_back(ref_ps(b_st));
    acc_q[0].push_back(cyc + 1);
    @(negedge clk);
    valid_i[0] = 1'b0;
    wait_valid(0);
    @(negedge clk);

    // Asynchronous reset in the middle of BUSY
    send(0, rand_state());
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_bit("midrst_valid", valid_o[0], 1'b0);
    check_bit("midrst_ready", ready_o[0], 1'b1);
    check_state("midrst_state", state_o[0], '0);
    drop_pending(0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(0, rand_state());
    wait_valid(0);
    @(negedge clk);

`ifdef ASCON_SUBST_CLEAR_EN
    // Clear during BUSY
    send(0, rand_state());
    @(negedge clk);
    clear_i[0] = 1'b1;
    @(negedge clk);
    clear_i[0] = 1'b0;
    #1;
    check_bit("clr_busy_valid", valid_o[0], 1'b0);
    check_bit("clr_busy_ready", ready_o[0], 1'b1);
    check_state("clr_busy_state", state_o[0], '0);
    drop_pending(0);
    repeat (6) @(negedge clk);

    // Clear during DONE while a new input is offered (must not be taken)
    ready_i[0] = 1'b0;
    send(0, rand_state());
    wait_valid(0);
    valid_i[0] = 1'b1;
    state_i[0] = rand_state();
    clear_i[0] = 1'b1;
    @(negedge clk);
    clear_i[0] = 1'b0;
    valid_i[0] = 1'b0;
    ready_i[0] = 1'b1;
    #1;
    check_bit("clr_done_valid", valid_o[0], 1'b0);
    check_bit("clr_done_ready", ready_o[0], 1'b1);
    check_state("clr_done_state", state_o[0], '0);
    repeat (6) @(negedge clk);
`endif

    // Everything issued must have come back
    repeat (80) @(negedge clk);
    for (int k = 0; k < NDUT; k++) begin
      check_int($sformatf("drain_dut%0d", k), exp_q[k].size(), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global bound on run time
  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion expected finish before 2000000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_substitution_layer_folded
`default_nettype wire
